// File: rtl/sensor_condition.sv
// eBike assist front end: synchronizes pedal cadence, measures it per window, averages
// motor current and crank torque, and produces the registered PID error and not_pedaling.
module sensor_condition #(
    parameter bit FAST_SIM = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cadence_raw,
    input  logic [11:0]        torque,
    input  logic [11:0]        curr,
    input  logic [11:0]        batt,
    input  logic signed [12:0] incline,
    input  logic [2:0]         scale,
    output logic signed [12:0] error,
    output logic               not_pedaling,
    output logic               cadence_rise
);

    localparam logic [11:0] TORQUE_DEADBAND = 12'h380;
    localparam logic [11:0] BATT_MIN        = 12'hA98;
    localparam logic [4:0]  CADENCE_MAX     = 5'd31;

    // ------------------------------------------------------------------
    // Cadence synchronizer: two metastability flops plus an edge flop
    // ------------------------------------------------------------------
    logic sync1;
    logic sync2;
    logic sync3;

    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= cadence_raw;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign cadence_rise = sync2 & ~sync3;

    // ------------------------------------------------------------------
    // Free-running period counter and the window / current-sample ticks
    // ------------------------------------------------------------------
    logic [21:0] period;
    logic        win_tick;
    logic        curr_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period <= '0;
        end else begin
            period <= period + 22'd1;
        end
    end

    assign win_tick  = FAST_SIM ? (&period[15:0]) : (&period[21:0]);
    assign curr_tick = FAST_SIM ? (&period[9:0])  : (&period[15:0]);

    // ------------------------------------------------------------------
    // Cadence count per window; a rise on the window tick opens the new window
    // ------------------------------------------------------------------
    logic [4:0] cadence_cnt;
    logic [4:0] cadence_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cadence_cnt <= '0;
            cadence_vec <= '0;
        end else if (win_tick) begin
            cadence_vec <= cadence_cnt;
            cadence_cnt <= {4'd0, cadence_rise};
        end else if (cadence_rise && (cadence_cnt != CADENCE_MAX)) begin
            cadence_cnt <= cadence_cnt + 5'd1;
        end
    end

    assign not_pedaling = (cadence_vec < 5'd2);

    // ------------------------------------------------------------------
    // Exponential averages; steady state is 4x curr and 32x torque, so no overflow
    // ------------------------------------------------------------------
    logic [13:0] curr_acc;
    logic [16:0] torq_acc;
    logic [11:0] avg_curr;
    logic [11:0] avg_torque;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curr_acc <= '0;
        end else if (curr_tick) begin
            curr_acc <= curr_acc - (curr_acc >> 2) + {2'b00, curr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            torq_acc <= '0;
        end else if (cadence_rise) begin
            torq_acc <= torq_acc - (torq_acc >> 5) + {5'd0, torque};
        end
    end

    assign avg_curr   = curr_acc[13:2];
    assign avg_torque = torq_acc[16:5];

    // ------------------------------------------------------------------
    // Target current from torque, incline, cadence and assist scale
    // ------------------------------------------------------------------
    logic [11:0]        torque_off;
    logic signed [9:0]  incline_sat;
    logic signed [10:0] incl_sum;
    logic [8:0]         incl_factor;
    logic [5:0]         cad_factor;
    logic [26:0]        prod;
    logic [26:0]        prod_shift;
    logic [11:0]        target_curr;
    logic [14:0]        scaled_full;
    logic [14:0]        scaled_shift;
    logic [11:0]        target_scaled;
    logic signed [12:0] err_next;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        torque_off = '0;
        if (avg_torque > TORQUE_DEADBAND) begin
            torque_off = avg_torque - TORQUE_DEADBAND;
        end

        incline_sat = incline[9:0];
        if (incline > 13'sd511) begin
            incline_sat = 10'sd511;
        end else if (incline < -13'sd512) begin
            incline_sat = -10'sd512;
        end

        incl_sum    = {incline_sat[9], incline_sat} + 11'sd256;
        incl_factor = incl_sum[8:0];
        if (incl_sum[10]) begin
            incl_factor = '0;
        end else if (incl_sum > 11'sd511) begin
            incl_factor = 9'd511;
        end

        cad_factor = 6'd0;
        if (cadence_vec > 5'd1) begin
            cad_factor = {1'b0, cadence_vec} + 6'd32;
        end
    end

    // Product is at most 3199*511*63, which fits the 27-bit result without wrapping.
    always_comb begin
        prod         = 27'(torque_off) * 27'(incl_factor) * 27'(cad_factor);
        prod_shift   = prod >> 11;
        target_curr  = (prod_shift > 27'd4095) ? 12'hFFF : prod_shift[11:0];

        scaled_full   = 15'(target_curr) * 15'(scale);
        scaled_shift  = scaled_full >> 2;
        target_scaled = (scaled_shift > 15'd4095) ? 12'hFFF : scaled_shift[11:0];

        err_next = $signed({1'b0, target_scaled} - {1'b0, avg_curr});
    end

    // ------------------------------------------------------------------
    // Registered PID error, forced to zero when idle or on a weak battery
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error <= '0;
        end else if (not_pedaling || (batt < BATT_MIN)) begin
            error <= '0;
        end else begin
            error <= err_next;
        end
    end

endmodule

// File: tb/tb_sensor_condition.sv
// Scoreboard bench for sensor_condition (FAST_SIM build): a driver feeds stimulus and an
// arithmetic reference model, a monitor compares every cycle's outputs against the queue.
module tb_sensor_condition;

    localparam int WIN   = 65536;
    localparam int CTICK = 1024;

    logic               clk         = 1'b0;
    logic               rst_n       = 1'b0;
    logic               cadence_raw = 1'b0;
    logic [11:0]        torque      = '0;
    logic [11:0]        curr        = '0;
    logic [11:0]        batt        = '0;
    logic signed [12:0] incline     = '0;
    logic [2:0]         scale       = '0;
    logic signed [12:0] error;
    logic               not_pedaling;
    logic               cadence_rise;

    sensor_condition #(.FAST_SIM(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cadence_raw  (cadence_raw),
        .torque       (torque),
        .curr         (curr),
        .batt         (batt),
        .incline      (incline),
        .scale        (scale),
        .error        (error),
        .not_pedaling (not_pedaling),
        .cadence_rise (cadence_rise)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] err;
        logic        np;
        logic        rise;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: edge index since reset, window count, averages, raw history.
    int k;
    int m_cnt;
    int m_vec;
    int m_cacc;
    int m_tacc;
    bit h1, h2, h3;
    int raw_hold;

    int incl_pts[12] = '{-4096, -600, -513, -512, -257, -256, 0, 255, 256, 511, 512, 4095};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h, required %h", name, $time, act, req);
        end
    endtask

    function automatic int clip(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Error the DUT registers on the coming edge, from the current averages and inputs.
    function automatic int model_error();
        int avg_t, avg_c, toff, ifac, cfac, prod, tgt, ts, inc_v;
        avg_t = m_tacc / 32;
        avg_c = m_cacc / 4;
        toff  = (avg_t > 896) ? avg_t - 896 : 0;
        inc_v = incline;
        ifac  = clip(clip(inc_v, -512, 511) + 256, 0, 511);
        cfac  = (m_vec > 1) ? m_vec + 32 : 0;
        prod  = toff * ifac * cfac;
        tgt   = (prod >= 8388608) ? 4095 : prod / 2048;
        ts    = clip(tgt * int'(scale) / 4, 0, 4095);
        if (m_vec < 2 || int'(batt) < 2712) return 0;
        return ts - avg_c;
    endfunction

    task automatic reset_model();
        k = 0; m_cnt = 0; m_vec = 0; m_cacc = 0; m_tacc = 0;
        h1 = 0; h2 = 0; h3 = 0;
    endtask

    // One clock: predict the post-edge outputs, advance the model, wait for the next negedge.
    task automatic step();
        exp_t e;
        int   err;
        bit   rise_used;
        err       = model_error();
        rise_used = h2 && !h3;
        e.rise    = h1 && !h2;
        if ((k % WIN) == WIN - 1) begin
            m_vec = m_cnt;
            m_cnt = rise_used ? 1 : 0;
        end else if (rise_used && m_cnt < 31) begin
            m_cnt++;
        end
        if ((k % CTICK) == CTICK - 1) m_cacc = m_cacc - m_cacc / 4 + int'(curr);
        if (rise_used) m_tacc = m_tacc - m_tacc / 32 + int'(torque);
        e.err = err[12:0];
        e.np  = (m_vec < 2);
        exp_q.push_back(e);
        h3 = h2; h2 = h1; h1 = cadence_raw;
        k++;
        @(negedge clk);
    endtask

    // 33 pulses early in the first window, then one whose rise lands on the window tick.
    function automatic bit phase_a_raw(input int kk);
        if (kk >= 100 && kk < 100 + 12 * 33) return ((kk - 100) % 12) < 6;
        return (kk >= WIN - 3) && (kk < WIN + 3);
    endfunction

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (raw_hold == 0) begin
                cadence_raw = ~cadence_raw;
                raw_hold    = $urandom_range(4, 12);
            end
            raw_hold--;
            torque = 12'($urandom);
            if ($urandom_range(0, 7) == 0) curr = 12'($urandom);
            case ($urandom_range(0, 3))
                0:       batt = 12'hA97;
                1:       batt = 12'hA98;
                2:       batt = 12'($urandom);
                default: batt = 12'hFFF;
            endcase
            if ($urandom_range(0, 1) == 0) incline = 13'($urandom);
            else incline = 13'(incl_pts[$urandom_range(0, 11)]);
            scale = 3'($urandom);
            step();
        end
    endtask

    // Monitor: compare every presented output against the oldest expectation.
    initial begin
        exp_t got;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                got = exp_q.pop_front();
                check("error", 32'($unsigned(error)), 32'(got.err));
                check("not_pedaling", 32'(not_pedaling), 32'(got.np));
                check("cadence_rise", 32'(cadence_rise), 32'(got.rise));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_err;
        int cur_err;
        int boost;

        raw_hold = 0;
        repeat (3) @(negedge clk);
        check("reset_error", 32'($unsigned(error)), 32'h0);
        check("reset_not_pedaling", 32'(not_pedaling), 32'h1);
        check("reset_cadence_rise", 32'(cadence_rise), 32'h0);
        rst_n = 1'b1;
        reset_model();

        // First window: averaged torque built up, current held at zero, error stays forced to 0.
        for (int i = 0; i < WIN; i++) begin
            cadence_raw = phase_a_raw(k);
            torque  = 12'hFFF;
            curr    = '0;
            batt    = 12'($urandom);
            incline = 13'($urandom);
            scale   = 3'($urandom);
            step();
        end
        check("window_not_pedaling", 32'(not_pedaling), 32'h0);

        // Saturated target and the battery threshold.
        cadence_raw = phase_a_raw(k);
        torque = 12'hFFF; curr = '0; incline = 13'h0FFF; scale = 3'd7; batt = 12'hFFF;
        step();
        check("saturation_error", 32'($unsigned(error)), 32'h0FFF);
        cadence_raw = phase_a_raw(k);
        batt = 12'hA97;
        step();
        check("low_batt_error", 32'($unsigned(error)), 32'h0);
        cadence_raw = phase_a_raw(k);
        batt = 12'hA98;
        step();
        check("batt_threshold_error", 32'($unsigned(error)), 32'h0FFF);

        // Zero assist exposes -avg_curr: step response to curr=0x400 from an empty average.
        scale = 3'd0; curr = 12'h400; batt = 12'hFFF;
        while (k <= WIN + CTICK) begin
            cadence_raw = phase_a_raw(k);
            step();
        end
        check("curr_first_tick", 32'($unsigned(error)), 32'h1F00);
        for (int t = 0; t < 6; t++) begin
            prev_err = error;
            repeat (CTICK) step();
            cur_err = error;
            check("curr_monotonic", 32'(cur_err < prev_err), 32'h1);
        end
        // One sample chosen to land the average exactly on 0x400, then hold 0x400.
        boost = 4096 - m_cacc + m_cacc / 4;
        curr  = 12'(boost);
        repeat (CTICK) step();
        curr = 12'h400;
        repeat (CTICK) step();
        check("curr_settled_scale0", 32'($unsigned(error)), 32'h1C00);

        // Randomized operation against the model.
        random_cycles(2000);

        // Arrange a live cadence_rise, then reset between edges.
        batt = 12'hFFF; scale = 3'd7; incline = 13'h0FFF;
        cadence_raw = 1'b0;
        repeat (6) step();
        cadence_raw = 1'b1;
        repeat (2) step();
        check("pre_reset_not_pedaling", 32'(not_pedaling), 32'h0);
        check("pre_reset_cadence_rise", 32'(cadence_rise), 32'h1);
        #1;
        rst_n = 1'b0;
        cadence_raw = 1'b0;
        #1;
        check("midrun_reset_error", 32'($unsigned(error)), 32'h0);
        check("midrun_reset_not_pedaling", 32'(not_pedaling), 32'h1);
        check("midrun_reset_cadence_rise", 32'(cadence_rise), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        reset_model();

        // No carry-over: the new window has no measured cadence yet.
        random_cycles(3000);
        check("post_reset_error", 32'($unsigned(error)), 32'h0);
        check("post_reset_not_pedaling", 32'(not_pedaling), 32'h1);

        @(posedge clk);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
